sram_bus_ctrl: RTL
==================

Name: sram_bus_ctrl

Overview:
- Downstream of the MEM stage.
- Consumes MEM's RAM request (address, chip enable, write enable, byte select, store data) and runs a multi-cycle access on the external 32-bit asynchronous SRAM.
- Returns load data to MEM and holds the pipeline with a stall request until the access completes.
- Accesses outside the SRAM window complete without touching the SRAM.

Parameters:
- WAIT_CYCLES, 1: cycles the SRAM strobes are held active per access phase; legal range 1..15.
- BASE_ADDR, 32'h8000_0000: first byte address of the SRAM window.
- ADDR_BITS, 20: SRAM word-address width; window size is 4 * 2^ADDR_BITS bytes.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active high.
- mem_ce_i  in  1  MEM requests a memory access this cycle.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  4  byte-lane enables for stores; bit n = byte n.
- mem_addr_i  in  32  byte address; bits [1:0] are ignored.
- mem_data_i  in  32  store data, already lane-aligned by MEM.
- mem_data_o  out  32  load data word returned to MEM.
- stallreq_o  out  1  hold the pipeline; combinational.
- sram_addr_o  out  ADDR_BITS  SRAM word address.
- sram_data_i  in  32  SRAM read bus.
- sram_data_o  out  32  SRAM write bus.
- sram_data_oe_o  out  1  1 = drive sram_data_o onto the pad.
- sram_ce_n_o  out  1  SRAM chip enable, active low.
- sram_oe_n_o  out  1  SRAM output enable, active low.
- sram_we_n_o  out  1  SRAM write enable, active low.
- sram_be_n_o  out  4  SRAM byte enables, active low.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state = IDLE, cnt = 0, mem_data_o = 0.
  - sram_ce_n/oe_n/we_n = 1, sram_be_n = 4'hF, sram_data_oe = 0, sram_addr = 0, sram_data_o = 0.
  - Reset during any state, including mid-write, returns to IDLE with all strobes inactive after that same edge.
- Window hit: in_win = (mem_addr_i >= BASE_ADDR) && (mem_addr_i < BASE_ADDR + 4*2^ADDR_BITS). Word address = mem_addr_i[ADDR_BITS+1:2].
- stallreq_o = mem_ce_i && (state != DONE).
- All SRAM outputs are registered and change only on clock edges.
- States: IDLE, READ, WRITE, WHOLD, DONE.
- IDLE:
  - mem_ce_i low: stay in IDLE.
  - Store with in_win and mem_sel_i != 0: go to WRITE.
    - Latch addr, sram_data_o = mem_data_i, be_n = ~mem_sel_i, ce_n = 0, we_n = 0, data_oe = 1, cnt = WAIT_CYCLES.
  - Load with in_win: go to READ.
    - Latch addr, be_n = 0, ce_n = 0, oe_n = 0, cnt = WAIT_CYCLES.
  - Otherwise (out-of-window access, or store with sel = 0): go directly to DONE.
    - Loads: mem_data_o = 0. Stores: no SRAM cycle.
- READ:
  - cnt decrements each cycle.
  - At the edge where cnt == 1: mem_data_o <= sram_data_i, ce_n = oe_n = 1, be_n = F, go to DONE.
  - READ therefore lasts exactly WAIT_CYCLES cycles.
- WRITE:
  - Same countdown.
  - At the edge where cnt == 1: we_n = 1 and go to WHOLD. ce_n, be_n, data and oe stay asserted, giving data hold after the rising edge of we_n.
- WHOLD (1 cycle): ce_n = 1, be_n = F, data_oe = 0, go to DONE.
- DONE (1 cycle):
  - stallreq_o = 0, so the pipeline advances this cycle.
  - mem_data_o holds the captured word and is unchanged until the next read capture or reset.
  - Always go to IDLE.
- Back-to-back accesses: a new request seen in IDLE the cycle after DONE starts a fresh access. No request is merged or skipped.
- Stall count per access:
  - In-window load: 1 + WAIT_CYCLES.
  - In-window store: 2 + WAIT_CYCLES.
  - Out-of-window or sel = 0: 1.
- mem_ce_i, mem_we_i, mem_addr_i, mem_data_i and mem_sel_i are sampled only in IDLE. Changes during READ, WRITE or WHOLD are ignored.
- The SRAM never sees oe_n = 0 and we_n = 0 together. data_oe = 1 only in WRITE and WHOLD.

Test Plan:
- Reset, then load 0x8000_0010 with SRAM model returning 0xDEADBEEF, WAIT_CYCLES = 1:
  - sram_addr = 0x00004 and oe_n = 0 for 1 cycle.
  - stallreq high for 2 cycles.
  - mem_data_o = 0xDEADBEEF in DONE.
- Store 0x1234_5678 to 0x8000_0020 with sel = 4'b0011:
  - be_n = 4'b1100, we_n low for 1 cycle, data_oe high for 2 cycles.
  - Stall for 3 cycles; SRAM word 8 low half = 0x5678.
- Load from 0x0000_0100 (out of window): no ce_n pulse, stall for 1 cycle, mem_data_o = 0.
- Back-to-back store then load to the same address with WAIT_CYCLES = 3: load returns the stored bytes; stalls of 5 then 4 cycles.
- Assert rst in the second cycle of WRITE:
  - Next edge: we_n = ce_n = 1, data_oe = 0, state IDLE, mem_data_o = 0.
  - stallreq follows mem_ce_i.
- Random mem_addr_i/mem_data_i changes during READ: sram_addr stays latched and the captured word is unaffected.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
// Multi-cycle bridge between the MEM stage RAM request and an external 32-bit
// asynchronous SRAM; stalls the pipeline until each access completes.
module sram_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned ADDR_BITS   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ce_i,
  input  logic                 mem_we_i,
  input  logic [3:0]           mem_sel_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          mem_data_i,
  output logic [31:0]          mem_data_o,
  output logic                 stallreq_o,
  output logic [ADDR_BITS-1:0] sram_addr_o,
  input  logic [31:0]          sram_data_i,
  output logic [31:0]          sram_data_o,
  output logic                 sram_data_oe_o,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o,
  output logic [3:0]           sram_be_n_o
);

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  // One past the last window byte, kept 33 bits wide so a window ending at 4 GiB still compares correctly.
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_BITS + 2));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_WHOLD = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   data_oe_q, data_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic [3:0]             be_n_q, be_n_d;
  logic                   in_win_s;
  logic [ADDR_BITS-1:0]   word_addr_s;

  assign in_win_s    = (mem_addr_i >= BASE_ADDR) && ({1'b0, mem_addr_i} < WIN_END);
  assign word_addr_s = mem_addr_i[ADDR_BITS+1:2];
  assign stallreq_o  = mem_ce_i && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_oe_d = data_oe_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    be_n_d    = be_n_q;
    case (state_q)
      S_IDLE: begin
        if (!mem_ce_i) begin
          state_d = S_IDLE;
        end else if (mem_we_i && in_win_s && (mem_sel_i != 4'b0000)) begin
          state_d   = S_WRITE;
          addr_d    = word_addr_s;
          wdata_d   = mem_data_i;
          be_n_d    = ~mem_sel_i;
          ce_n_d    = 1'b0;
          we_n_d    = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = WAIT_INIT;
        end else if (!mem_we_i && in_win_s) begin
          state_d = S_READ;
          addr_d  = word_addr_s;
          be_n_d  = 4'b0000;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          cnt_d   = WAIT_INIT;
        end else begin
          // Out-of-window or empty-lane store: complete without an SRAM cycle.
          state_d = S_DONE;
          if (!mem_we_i) begin
            rdata_d = 32'h0000_0000;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      S_READ: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = sram_data_i;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = 4'hF;
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Release we_n first; ce_n, lanes and data stay put one more cycle for hold time.
          we_n_d  = 1'b1;
          state_d = S_WHOLD;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WHOLD: begin
        ce_n_d    = 1'b1;
        be_n_d    = 4'hF;
        data_oe_d = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = 4'hF;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rdata_q   <= 32'h0000_0000;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      data_oe_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_oe_q <= data_oe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
    end
  end

  assign mem_data_o     = rdata_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign sram_be_n_o    = be_n_q;

endmodule
